// File: rtl/imm_ext_pipe_if.sv
// Request/response bundle for the immediate-extension pipe: request side
// (valid/ready, imm, EOp) and buffered result side (valid/ready, ext, err, count).
interface imm_ext_pipe_if #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [IMM_W-1:0]         imm;
  logic [2:0]               EOp;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         ext;
  logic                     err;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, imm, EOp, out_ready,
    input  in_ready, out_valid, ext, err, count
  );

  modport slave (
    input  in_valid, imm, EOp, out_ready,
    output in_ready, out_valid, ext, err, count
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extender: computes the extended value at accept time and queues
// {err, ext} in a DEPTH-entry FIFO; the head is presented one cycle later.
module imm_ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  imm_ext_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = OUT_W - IMM_W;

  logic [OUT_W-1:0] zext, sext, ext_new;
  logic             err_new;
  logic [OUT_W:0]   mem [DEPTH];
  logic [OUT_W:0]   head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push, pop, not_empty;

  always_comb begin
    zext    = {{PW{1'b0}}, bus.imm};
    sext    = {{PW{bus.imm[IMM_W-1]}}, bus.imm};
    ext_new = '0;
    err_new = 1'b0;
    case (bus.EOp)
      3'b000:  ext_new = zext;
      3'b001:  ext_new = sext;
      3'b010:  ext_new = {bus.imm, {PW{1'b0}}};
      3'b011:  ext_new = sext << 2;
      3'b100:  ext_new = zext << 2;
      default: err_new = 1'b1;
    endcase
  end

  assign not_empty    = (count_q != '0);
  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = not_empty && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible unless count says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {err_new, ext_new};
  end

  // Gating the head with not_empty makes ext/err drop to 0 together with
  // count during an asynchronous reset.
  assign head          = mem[rd_ptr];
  assign bus.out_valid = not_empty;
  assign bus.ext       = not_empty ? head[OUT_W-1:0] : '0;
  assign bus.err       = not_empty ? head[OUT_W] : 1'b0;
  assign bus.count     = count_q;
endmodule
